// File: rtl/spi_pkg.sv
// Shared definitions for the SPI datapath blocks.
//   - FSM state encoding for spi_shift_engine. The unused code 2'd3 is
//     decoded as IDLE by the engine.
//   - cnt_w(): width of a counter able to hold 0..w. The SCLK generator
//     uses it too.
package spi_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Parallel-side bus of spi_shift_engine.
//   tx_data/tx_valid/tx_ready : transmit frame load handshake
//   rx_data/rx_valid          : received frame and its one-cycle update pulse
//   busy, bit_cnt             : frame status
// master = byte-level controller side, slave = shift engine side.
interface spi_shift_engine_if
   import spi_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int CNT_W = cnt_w(WIDTH);

   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, busy, bit_cnt
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, busy, bit_cnt
   );

endinterface

// File: rtl/spi_shift_engine.sv
// Parametrised SPI shift engine.
// Loads a WIDTH-bit frame through a valid/ready handshake, shifts it out one
// bit per shift strobe while shifting received bits in, and publishes the
// received frame with a one-cycle rx_valid pulse.
// Ports:
//   i_clk        : clock, rising edge
//   i_clear      : synchronous active-high reset, dominates all other inputs
//   if_bus       : parallel bus (tx handshake, rx frame, busy, bit_cnt)
//   i_sample_en  : strobe, capture i_serial_in
//   i_shift_en   : strobe, shift one bit toward the serial output end
//   i_serial_in  : receive bit
//   o_serial_out : transmit bit (0 outside ACTIVE)
module spi_shift_engine
   import spi_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_clear,
   spi_shift_engine_if.slave    if_bus,
   input  logic                 i_sample_en,
   input  logic                 i_shift_en,
   input  logic                 i_serial_in,
   output logic                 o_serial_out
);

   localparam int CNT_W = cnt_w(WIDTH);

   logic [WIDTH-1:0] r_shreg;
   logic             r_samp_bit;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;

   logic [1:0]       w_state;
   logic             w_ins_bit;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tx_bit;

   // Unused encoding falls back to IDLE.
   assign w_state = (r_state == ST_ACTIVE || r_state == ST_DONE) ? r_state : ST_IDLE;

   // Same-cycle sample and shift bypasses the sample register.
   assign w_ins_bit = (i_sample_en && i_shift_en) ? i_serial_in : r_samp_bit;

   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shreg_nxt = {r_shreg[WIDTH-2:0], w_ins_bit};
         assign w_tx_bit    = r_shreg[WIDTH-1];
      end else begin : g_lsb
         assign w_shreg_nxt = {w_ins_bit, r_shreg[WIDTH-1:1]};
         assign w_tx_bit    = r_shreg[0];
      end
   endgenerate

   assign w_cnt_nxt = r_bit_cnt + CNT_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_shreg    <= '0;
         r_samp_bit <= 1'b0;
         r_bit_cnt  <= '0;
         r_state    <= ST_IDLE;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (w_state)
            ST_ACTIVE: begin
               if (i_sample_en)
                  r_samp_bit <= i_serial_in;
               if (i_shift_en) begin
                  r_shreg   <= w_shreg_nxt;
                  r_bit_cnt <= w_cnt_nxt;
                  // Leave ACTIVE on the last bit so bit_cnt never passes WIDTH.
                  if (w_cnt_nxt == CNT_W'(WIDTH)) begin
                     r_rx_data  <= w_shreg_nxt;
                     r_rx_valid <= 1'b1;
                     r_state    <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               if (if_bus.tx_valid) begin
                  r_shreg    <= if_bus.tx_data;
                  r_bit_cnt  <= '0;
                  r_samp_bit <= 1'b0;
                  r_state    <= ST_ACTIVE;
               end
            end
         endcase
      end
   end

   assign if_bus.tx_ready = (w_state == ST_IDLE);
   assign if_bus.busy     = (w_state == ST_ACTIVE) || (w_state == ST_DONE);
   assign if_bus.rx_data  = r_rx_data;
   assign if_bus.rx_valid = r_rx_valid;
   assign if_bus.bit_cnt  = r_bit_cnt;
   assign o_serial_out    = (w_state == ST_ACTIVE) ? w_tx_bit : 1'b0;

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;

   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   // Instance A: MSB first, instance B: LSB first.
   spi_shift_engine_if #(.WIDTH(8)) ifa ();
   spi_shift_engine_if #(.WIDTH(8)) ifb ();

   logic a_sample, a_shift, a_sin, a_sin_drv, a_sout, a_loop;
   logic b_sample, b_shift, b_sin, b_sout;

   assign a_sin = a_loop ? a_sout : a_sin_drv;

   spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
      .i_clk(clk), .i_clear(clear), .if_bus(ifa),
      .i_sample_en(a_sample), .i_shift_en(a_shift),
      .i_serial_in(a_sin), .o_serial_out(a_sout)
   );

   spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
      .i_clk(clk), .i_clear(clear), .if_bus(ifb),
      .i_sample_en(b_sample), .i_shift_en(b_shift),
      .i_serial_in(b_sin), .o_serial_out(b_sout)
   );

   int npass = 0;
   int nfail = 0;
   int ntot  = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample after the edge, and retire any completed frame
   // against the scoreboard.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (ifa.rx_valid === 1'b1) begin
         chk("a_rx_expected", 32'(qa.size() > 0), 32'd1);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_rx_data", 32'(ifa.rx_data), 32'(e));
         end
      end
      if (ifb.rx_valid === 1'b1) begin
         chk("b_rx_expected", 32'(qb.size() > 0), 32'd1);
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_rx_data", 32'(ifb.rx_data), 32'(e));
         end
      end
   endtask

   task automatic load_a(input logic [7:0] d, input bit expect_done);
      ifa.tx_data  = d;
      ifa.tx_valid = 1'b1;
      if (expect_done) qa.push_back(d);
      tick();
      ifa.tx_valid = 1'b0;
      chk("a_busy_after_load", 32'(ifa.busy), 32'd1);
      chk("a_cnt_after_load", 32'(ifa.bit_cnt), 32'd0);
   endtask

   // Loopback frame on A: sample then shift for each bit.
   task automatic shift8_a(input logic [7:0] tx);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a_sout_bit%0d", i), 32'(a_sout), 32'(tx[7-i]));
         chk("a_tx_ready_active", 32'(ifa.tx_ready), 32'd0);
         a_sample = 1'b1;
         tick();
         a_sample = 1'b0;
         a_shift  = 1'b1;
         tick();
         a_shift  = 1'b0;
         chk($sformatf("a_cnt_step%0d", i), 32'(ifa.bit_cnt), 32'(i + 1));
      end
      chk("a_rx_valid_done", 32'(ifa.rx_valid), 32'd1);
      chk("a_rx_data_done", 32'(ifa.rx_data), 32'(tx));
      chk("a_busy_done", 32'(ifa.busy), 32'd1);
      chk("a_tx_ready_done", 32'(ifa.tx_ready), 32'd0);
   endtask

   initial begin
      logic [7:0] sb_rx;
      logic [7:0] sb_tx;
      clear = 1'b1;
      ifa.tx_data = 8'h77; ifa.tx_valid = 1'b1;
      ifb.tx_data = 8'h77; ifb.tx_valid = 1'b1;
      a_sample = 0; a_shift = 0; a_sin_drv = 0; a_loop = 1'b1;
      b_sample = 0; b_shift = 0; b_sin = 0;

      // Reset with tx_valid asserted: nothing loads.
      tick();
      tick();
      chk("rst_tx_ready", 32'(ifa.tx_ready), 32'd1);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_sout", 32'(a_sout), 32'd0);
      chk("rst_rx_data", 32'(ifa.rx_data), 32'd0);
      chk("rst_cnt", 32'(ifa.bit_cnt), 32'd0);
      chk("rst_rx_valid", 32'(ifa.rx_valid), 32'd0);
      chk("rst_b_busy", 32'(ifb.busy), 32'd0);
      clear = 1'b0;
      ifa.tx_valid = 1'b0;
      ifb.tx_valid = 1'b0;
      tick();
      chk("idle_busy", 32'(ifa.busy), 32'd0);

      // Loopback MSB first.
      load_a(8'hA5, 1'b1);
      shift8_a(8'hA5);
      tick();
      chk("a5_idle_tx_ready", 32'(ifa.tx_ready), 32'd1);
      chk("a5_idle_rx_valid", 32'(ifa.rx_valid), 32'd0);
      chk("a5_rx_hold", 32'(ifa.rx_data), 32'hA5);

      // LSB first, serial_in driven with 8'hC3 LSB first.
      sb_tx = 8'h3C;
      sb_rx = 8'hC3;
      ifb.tx_data = sb_tx; ifb.tx_valid = 1'b1;
      qb.push_back(sb_rx);
      tick();
      ifb.tx_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("b_sout_bit%0d", i), 32'(b_sout), 32'(sb_tx[i]));
         b_sin = sb_rx[i];
         b_sample = 1'b1;
         tick();
         b_sample = 1'b0;
         b_shift  = 1'b1;
         tick();
         b_shift  = 1'b0;
      end
      chk("b_rx_valid", 32'(ifb.rx_valid), 32'd1);
      chk("b_rx_data", 32'(ifb.rx_data), 32'hC3);
      tick();
      chk("b_idle", 32'(ifb.tx_ready), 32'd1);

      // Bypass: sample and shift together every cycle.
      a_loop = 1'b0;
      sb_rx = 8'h81;
      load_a(8'h00, 1'b0);
      qa.push_back(sb_rx);
      for (int i = 0; i < 8; i++) begin
         a_sin_drv = sb_rx[7-i];
         a_sample = 1'b1;
         a_shift  = 1'b1;
         if (i == 7) begin
            tick();
            a_sample = 1'b0;
            a_shift  = 1'b0;
         end else begin
            tick();
         end
         chk($sformatf("byp_cnt%0d", i), 32'(ifa.bit_cnt), 32'(i + 1));
      end
      chk("byp_rx_valid", 32'(ifa.rx_valid), 32'd1);
      chk("byp_rx_data", 32'(ifa.rx_data), 32'h81);
      tick();
      chk("byp_rx_valid_drop", 32'(ifa.rx_valid), 32'd0);
      a_loop = 1'b1;

      // Handshake: tx_valid held with 8'hFF through ACTIVE and DONE.
      load_a(8'h96, 1'b1);
      ifa.tx_data  = 8'hFF;
      ifa.tx_valid = 1'b1;
      shift8_a(8'h96);
      tick();
      chk("hs_idle_tx_ready", 32'(ifa.tx_ready), 32'd1);
      chk("hs_idle_busy", 32'(ifa.busy), 32'd0);
      load_a(8'hFF, 1'b1);
      chk("hs_ff_sout", 32'(a_sout), 32'd1);
      shift8_a(8'hFF);
      tick();

      // Mid-frame reset after 3 shifts.
      load_a(8'h33, 1'b0);
      for (int i = 0; i < 3; i++) begin
         a_sample = 1'b1;
         tick();
         a_sample = 1'b0;
         a_shift  = 1'b1;
         tick();
         a_shift  = 1'b0;
      end
      chk("mid_cnt_before", 32'(ifa.bit_cnt), 32'd3);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("mid_tx_ready", 32'(ifa.tx_ready), 32'd1);
      chk("mid_busy", 32'(ifa.busy), 32'd0);
      chk("mid_cnt", 32'(ifa.bit_cnt), 32'd0);
      chk("mid_rx_data", 32'(ifa.rx_data), 32'd0);
      chk("mid_rx_valid", 32'(ifa.rx_valid), 32'd0);
      tick();
      chk("mid_rx_valid2", 32'(ifa.rx_valid), 32'd0);
      load_a(8'h5A, 1'b1);
      shift8_a(8'h5A);
      tick();
      chk("5a_rx_hold", 32'(ifa.rx_data), 32'h5A);

      chk("sb_a_drained", 32'(qa.size()), 32'd0);
      chk("sb_b_drained", 32'(qb.size()), 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
